// File: rtl/axi_pkg.sv
// axi_pkg: shared read-FSM encodings and AXI response codes for the SRAM slave.
package axi_pkg;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} rstate_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_sram_if.sv
// axi_sram_if: AXI-style read/write channel bundle between a master and the SRAM slave.
interface axi_sram_if #(parameter int ID_W = 4);
    logic [ID_W-1:0] s_arid;
    logic [31:0]     s_araddr;
    logic [7:0]      s_arlen;
    logic            s_arvalid;
    logic            s_arready;
    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;
    logic [ID_W-1:0] s_awid;
    logic [31:0]     s_awaddr;
    logic            s_awvalid;
    logic            s_awready;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        input  s_awid, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_awready, s_wready, s_bid, s_bresp, s_bvalid
    );
    modport master (
        output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        output s_awid, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_awready, s_wready, s_bid, s_bresp, s_bvalid
    );
endinterface

// File: rtl/sram_sp.sv
// sram_sp: single-port 32-bit SRAM with byte write enables and 1-cycle synchronous read.
module sram_sp #(parameter int AW = 10) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    output logic [31:0]   o_q
);
    logic [31:0] r_mem [2**AW];
    logic [31:0] r_q;
    always_ff @(posedge clk) begin
        if (i_we)
            for (int i = 0; i < 4; i++)
                if (i_wstrb[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        if (i_en) r_q <= r_mem[i_addr];
    end
    assign o_q = r_q;
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI slave with INCR read bursts and single-beat writes onto a single-port SRAM.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int ID_W = 4
) (
    input logic clk,
    input logic reset,
    axi_sram_if.slave s
);
    rstate_t               r_state;
    logic [ID_W-1:0]       r_rid, r_aw_id;
    logic [DEPTH_LOG2-1:0] r_idx, r_aw_idx;
    logic [3:0]            r_len, r_beat, r_wstrb;
    logic [31:0]           r_wdata, w_q;
    logic                  r_aw_v, r_w_v, r_bvalid;
    logic                  w_wr, w_rd, w_last, w_rvalid, w_unused;
    // A write commit owns the single SRAM port; a pending read issue waits a cycle.
    assign w_wr     = r_aw_v && r_w_v && !r_bvalid;
    assign w_rd     = r_state == R_ISSUE && !w_wr;
    assign w_last   = r_beat == r_len;
    assign w_rvalid = r_state == R_DATA;
    assign w_unused = &{1'b0, s.s_araddr[31:DEPTH_LOG2+2], s.s_araddr[1:0], s.s_arlen[7:4],
                        s.s_awaddr[31:DEPTH_LOG2+2], s.s_awaddr[1:0]};
    sram_sp #(.AW(DEPTH_LOG2)) u_sram (
        .clk     (clk),
        .i_en    (w_rd),
        .i_we    (w_wr),
        .i_addr  (w_wr ? r_aw_idx : r_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .o_q     (w_q)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_rid   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s.s_arvalid) begin
                    r_rid   <= s.s_arid;
                    r_idx   <= s.s_araddr[DEPTH_LOG2+1:2];
                    r_len   <= s.s_arlen[3:0];
                    r_beat  <= '0;
                    r_state <= R_ISSUE;
                end
                R_ISSUE: if (!w_wr) r_state <= R_DATA;
                R_DATA: if (s.s_rready) begin
                    r_idx   <= r_idx + 1'b1;
                    r_beat  <= r_beat + 1'b1;
                    r_state <= w_last ? R_IDLE : R_ISSUE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_v   <= 1'b0;
            r_w_v    <= 1'b0;
            r_bvalid <= 1'b0;
            r_aw_id  <= '0;
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (s.s_awvalid && !r_aw_v) begin
                r_aw_v   <= 1'b1;
                r_aw_id  <= s.s_awid;
                r_aw_idx <= s.s_awaddr[DEPTH_LOG2+1:2];
            end
            if (s.s_wvalid && !r_w_v) begin
                r_w_v   <= 1'b1;
                r_wdata <= s.s_wdata;
                r_wstrb <= s.s_wstrb;
            end
            if (w_wr) r_bvalid <= 1'b1;
            if (r_bvalid && s.s_bready) begin
                r_aw_v   <= 1'b0;
                r_w_v    <= 1'b0;
                r_bvalid <= 1'b0;
            end
        end
    end
    assign s.s_arready = r_state == R_IDLE;
    assign s.s_rvalid  = w_rvalid;
    assign s.s_rlast   = w_rvalid && w_last;
    assign s.s_rid     = r_rid;
    assign s.s_rdata   = w_rvalid ? w_q : '0;
    assign s.s_rresp   = RESP_OKAY;
    assign s.s_awready = !r_aw_v;
    assign s.s_wready  = !r_w_v;
    assign s.s_bid     = r_aw_id;
    assign s.s_bresp   = RESP_OKAY;
    assign s.s_bvalid  = r_bvalid;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_axi_sram_slave;
    localparam int ID_W = 4;
    typedef struct {logic [3:0] id; logic [31:0] data; logic last;} rbeat_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    axi_sram_if #(.ID_W(ID_W)) bus();
    axi_sram_slave #(.DEPTH_LOG2(10), .ID_W(ID_W)) dut (.clk(clk), .reset(reset), .s(bus));
    always #5 clk = ~clk;
    rbeat_t rq[$];
    logic [3:0] bq[$];
    logic [31:0] exp_mem [int];
    int n_vec = 0;
    int n_bad = 0;
    int beats_done = 0;
    bit toggle_rr = 1'b0;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no response within bound, expected one", name);
    endtask
    // Monitor: compares whatever the DUT presents against the head of the expected queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.s_rvalid) begin
                if (rq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL r_unexpected: got beat %h expected none", bus.s_rdata);
                end else begin
                    chk("rdata", bus.s_rdata, rq[0].data);
                    chk("rid", 32'(bus.s_rid), 32'(rq[0].id));
                    chk("rlast", 32'(bus.s_rlast), 32'(rq[0].last));
                    chk("rresp", 32'(bus.s_rresp), 32'd0);
                    if (bus.s_rready) begin
                        void'(rq.pop_front());
                        beats_done++;
                    end
                end
            end
            if (bus.s_bvalid && bus.s_bready) begin
                if (bq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b_unexpected: got bid %h expected none", bus.s_bid);
                end else begin
                    chk("bid", 32'(bus.s_bid), 32'(bq[0]));
                    chk("bresp", 32'(bus.s_bresp), 32'd0);
                    void'(bq.pop_front());
                end
            end
        end
    end
    initial begin
        bus.s_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.s_rready = toggle_rr ? ~bus.s_rready : 1'b1;
        end
    end
    task automatic chk_idle(input string tag);
        chk({tag, "_arready"}, 32'(bus.s_arready), 32'd1);
        chk({tag, "_awready"}, 32'(bus.s_awready), 32'd1);
        chk({tag, "_wready"}, 32'(bus.s_wready), 32'd1);
        chk({tag, "_rvalid"}, 32'(bus.s_rvalid), 32'd0);
        chk({tag, "_rlast"}, 32'(bus.s_rlast), 32'd0);
        chk({tag, "_bvalid"}, 32'(bus.s_bvalid), 32'd0);
        chk({tag, "_rid"}, 32'(bus.s_rid), 32'd0);
        chk({tag, "_bid"}, 32'(bus.s_bid), 32'd0);
        chk({tag, "_rdata"}, bus.s_rdata, 32'd0);
    endtask
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        logic [31:0] m;
        idx = int'(addr[11:2]);
        m = exp_mem.exists(idx) ? exp_mem[idx] : 32'd0;
        for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = data[8*i +: 8];
        exp_mem[idx] = m;
    endtask
    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; 0: same cycle.
    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int gap, output int lat);
        int n = 0;
        while (!(bus.s_awready && bus.s_wready) && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("wr_ready");
        bus.s_awid = id; bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
        if (gap == 0) begin
            bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; tick();
            bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        end else if (gap > 0) begin
            bus.s_wvalid = 1'b1; tick(); bus.s_wvalid = 1'b0;
            repeat (gap - 1) tick();
            bus.s_awvalid = 1'b1; tick(); bus.s_awvalid = 1'b0;
        end else begin
            bus.s_awvalid = 1'b1; tick(); bus.s_awvalid = 1'b0;
            repeat (-gap - 1) tick();
            bus.s_wvalid = 1'b1; tick(); bus.s_wvalid = 1'b0;
        end
        model_write(addr, data, strb);
        bq.push_back(id);
        lat = 0;
        while (!bus.s_bvalid && lat < 20) begin tick(); lat++; end
        if (!bus.s_bvalid) timeout("wr_bvalid");
    endtask
    task automatic push_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
        rbeat_t e;
        e.id = id; e.data = data; e.last = last;
        rq.push_back(e);
    endtask
    task automatic push_model(input logic [3:0] id, input logic [31:0] addr, input int len);
        for (int b = 0; b <= len; b++)
            push_beat(id, exp_mem[(int'(addr[11:2]) + b) % 1024], b == len);
    endtask
    task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, output int lat);
        int n = 0;
        while (!bus.s_arready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("ar_ready");
        bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        lat = 0;
        while (!bus.s_rvalid && lat < 20) begin tick(); lat++; end
        if (!bus.s_rvalid) timeout("ar_rvalid");
    endtask
    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin tick(); n++; end
        if (n >= 300) timeout("drain");
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected one");
        $fatal(1);
    end
    initial begin
        int lat;
        int n;
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arvalid = 1'b0;
        bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        wr(4'd3, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat);
        chk("b_latency", 32'(lat), 32'd1);
        drain();
        push_beat(4'd5, 32'hDEADBEEF, 1'b1);
        ar(4'd5, 32'h10, 8'd0, lat);
        chk("r_latency", 32'(lat), 32'd1);
        drain();
        wr(4'd1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, lat);
        drain();
        wr(4'd2, 32'h20, 32'h11223344, 4'b0101, 3, lat);
        drain();
        push_beat(4'd4, 32'hFF22FF44, 1'b1);
        ar(4'd4, 32'h20, 8'd0, lat);
        drain();
        wr(4'd6, 32'h10, 32'h01234567, 4'h0, -2, lat);
        drain();
        push_beat(4'd6, 32'hDEADBEEF, 1'b1);
        ar(4'd6, 32'h10, 8'd0, lat);
        drain();
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 0, lat);
            drain();
        end
        toggle_rr = 1'b1;
        for (int b = 0; b < 4; b++) push_beat(4'd9, 32'hA0 + 32'(b), b == 3);
        ar(4'd9, 32'h0, 8'd3, lat);
        drain();
        toggle_rr = 1'b0;
        tick();
        wr(4'd1, 32'hFF8, 32'hC0DE03FE, 4'hF, 0, lat); drain();
        wr(4'd2, 32'hFFC, 32'hC0DE03FF, 4'hF, 0, lat); drain();
        wr(4'd3, 32'h000, 32'h000000B0, 4'hF, 0, lat); drain();
        wr(4'd4, 32'h004, 32'h000000B1, 4'hF, 0, lat); drain();
        push_beat(4'd10, 32'hC0DE03FE, 1'b0);
        push_beat(4'd10, 32'hC0DE03FF, 1'b0);
        push_beat(4'd10, 32'h000000B0, 1'b0);
        push_beat(4'd10, 32'h000000B1, 1'b1);
        ar(4'd10, 32'hFF8, 8'd3, lat);
        drain();
        bus.s_awid = 4'd2; bus.s_awaddr = 32'h30; bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'hF;
        bus.s_arid = 4'd6; bus.s_araddr = 32'h30; bus.s_arlen = 8'd0;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        model_write(32'h30, 32'h12345678, 4'hF);
        bq.push_back(4'd2);
        push_beat(4'd6, 32'h12345678, 1'b1);
        lat = 0;
        while (!bus.s_rvalid && lat < 20) begin tick(); lat++; end
        chk("collide_r_latency", 32'(lat), 32'd2);
        drain();
        bus.s_bready = 1'b0;
        wr(4'd8, 32'h40, 32'h55AA55AA, 4'hF, 0, lat);
        n = beats_done;
        push_model(4'd7, 32'h0, 3);
        ar(4'd7, 32'h0, 8'd3, lat);
        lat = 0;
        while (beats_done < n + 2 && lat < 100) begin tick(); lat++; end
        if (beats_done < n + 2) timeout("mid_burst");
        chk("b_pending", 32'(bus.s_bvalid), 32'd1);
        reset = 1'b1;
        tick();
        chk_idle("mid_reset");
        rq.delete();
        bq.delete();
        reset = 1'b0;
        bus.s_bready = 1'b1;
        tick();
        push_beat(4'd11, 32'h55AA55AA, 1'b1);
        ar(4'd11, 32'h40, 8'd0, lat);
        drain();
        push_beat(4'd12, 32'h000000B0, 1'b0);
        push_beat(4'd12, 32'h000000B1, 1'b1);
        ar(4'd12, 32'h0, 8'd1, lat);
        drain();
        wr(4'd13, 32'h44, 32'h0BADF00D, 4'hF, 0, lat);
        drain();
        push_beat(4'd14, 32'h0BADF00D, 1'b1);
        ar(4'd14, 32'h44, 8'd0, lat);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
